// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter onto a single memory port with per-transaction timeout.
// Optional round-robin arbitration when ARB_ROUND_ROBIN_EN is defined (fixed D-priority otherwise).
module mem_arbiter #(
    parameter int unsigned ARCH    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [ARCH-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_valid,
    output logic            if_err,
    output logic [ARCH-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ARCH-1:0] d_addr,
    input  logic [ARCH-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_gnt,
    output logic            d_valid,
    output logic            d_err,
    output logic [ARCH-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [ARCH-1:0] mem_addr,
    output logic [ARCH-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [ARCH-1:0] mem_rdata
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t          state_q;
    logic            owner_q;
    logic [CW-1:0]   cnt_q;
    logic [ARCH-1:0] addr_q;
    logic [ARCH-1:0] wdata_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic            if_valid_q;
    logic            if_err_q;
    logic [ARCH-1:0] if_rdata_q;
    logic            d_valid_q;
    logic            d_err_q;
    logic [ARCH-1:0] d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic            prefer_d_q;
`endif

    logic            gnt_if_c;
    logic            gnt_d_c;
    logic            busy_c;
    logic [ARCH-1:0] resp_rdata_d;

    // Same-cycle grant decision; only legal while idle and out of reset.
    always_comb begin
        gnt_if_c = 1'b0;
        gnt_d_c  = 1'b0;
        if (!reset && state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && (!if_req || prefer_d_q)) begin
                gnt_d_c = 1'b1;
            end else if (if_req) begin
                gnt_if_c = 1'b1;
            end
`else
            if (d_req) begin
                gnt_d_c = 1'b1;
            end else if (if_req) begin
                gnt_if_c = 1'b1;
            end
`endif
        end
    end

    // Stores return zero read data.
    assign resp_rdata_d = we_q ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_d_q <= 1'b1;
`endif
        end else begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_d_c) begin
                        state_q <= BUSY;
                        owner_q <= OWN_D;
                        cnt_q   <= '0;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        we_q    <= d_we;
                        be_q    <= d_be;
`ifdef ARB_ROUND_ROBIN_EN
                        prefer_d_q <= 1'b0;
`endif
                    end else if (gnt_if_c) begin
                        state_q <= BUSY;
                        owner_q <= OWN_I;
                        cnt_q   <= '0;
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                        be_q    <= 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
                        prefer_d_q <= 1'b1;
`endif
                    end
                end
                BUSY: begin
                    // cnt_q holds the number of earlier BUSY cycles; a ready on the last one still completes.
                    if (mem_ready) begin
                        state_q <= IDLE;
                        if (owner_q == OWN_D) begin
                            d_valid_q <= 1'b1;
                            d_rdata_q <= resp_rdata_d;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= resp_rdata_d;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        if (owner_q == OWN_D) begin
                            d_valid_q <= 1'b1;
                            d_err_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_err_q   <= 1'b1;
                            if_rdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset forces every output low in the very cycle it is sampled.
    assign busy_c    = (state_q == BUSY) && !reset;
    assign if_gnt    = gnt_if_c;
    assign d_gnt     = gnt_d_c;
    assign mem_req   = busy_c;
    assign mem_we    = busy_c && we_q;
    assign mem_addr  = busy_c ? addr_q  : '0;
    assign mem_wdata = busy_c ? wdata_q : '0;
    assign mem_be    = busy_c ? be_q    : 4'h0;
    assign if_valid  = if_valid_q && !reset;
    assign if_err    = if_err_q && !reset;
    assign if_rdata  = reset ? '0 : if_rdata_q;
    assign d_valid   = d_valid_q && !reset;
    assign d_err     = d_err_q && !reset;
    assign d_rdata   = reset ? '0 : d_rdata_q;

endmodule
